// File: rtl/axi_master_interface_pkg.sv
// Shared AXI constants and write-FSM state encoding for axi_master_interface.
package axi_master_interface_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DATA  = 2'd1,
        W_WAITA = 2'd2
    } wr_state_t;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_master_req_slice.sv
// One-entry address/length request register feeding an AXI AW or AR channel.
module axi_master_req_slice #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_len,
    input  logic                  ready,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [7:0]            len
);

    // addr/len are kept after the channel handshake; the write path still reads len for WLAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            len   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= req_addr;
            len   <= req_len;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_master_interface.sv
// Simple user-side to AXI4 master bridge with outstanding-burst limiting and sticky error flags.
// Optional macro AXI_MASTER_WRITE_AFTER_ADDR_EN holds W beats until the burst's AW is accepted.
module axi_master_interface
    import axi_master_interface_pkg::*;
#(
    parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXI_AWUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_WUSER_WIDTH  = 1,
    parameter int unsigned C_M_AXI_RUSER_WIDTH  = 1,
    parameter int unsigned C_M_AXI_BUSER_WIDTH  = 1,
    parameter int unsigned MAX_OUTSTANDING      = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              awvalid,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                        awlen,
    output logic                              awready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata,
    input  logic                              wvalid,
    output logic                              wready,
    output logic                              bvalid,
    input  logic                              bready,
    input  logic                              arvalid,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                        arlen,
    output logic                              arready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rdata,
    output logic                              rlast,
    output logic                              rvalid,
    input  logic                              rready,
    output logic [1:0]                        err_status,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic [1:0]                        M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWREGION,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]    M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]    M_AXI_BUSER,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic [1:0]                        M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARREGION,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]    M_AXI_RUSER,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned     CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [2:0]      SIZE    = axi_size(C_M_AXI_DATA_WIDTH);

    wr_state_t       wr_state, wr_next;
    logic            ready_en;
    logic [7:0]      beat;
    logic [CW-1:0]   wr_out, rd_out;
    logic            aw_pending, ar_pending;
    logic [7:0]      aw_len;
    logic            user_aw_hs, user_ar_hs, aw_hs, ar_hs, w_hs, b_hs, r_hs, rlast_hs;
    logic            w_gate, wlast;
    logic            unused_in;

    assign unused_in = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RUSER};

`ifdef AXI_MASTER_WRITE_AFTER_ADDR_EN
    assign w_gate = !aw_pending;
`else
    assign w_gate = 1'b1;
`endif

    assign user_aw_hs = awvalid && awready;
    assign user_ar_hs = arvalid && arready;
    assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
    assign ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs       = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;
    assign rlast_hs   = r_hs && M_AXI_RLAST;
    assign wlast      = (beat == aw_len);

    axi_master_req_slice #(.ADDR_WIDTH(C_M_AXI_ADDR_WIDTH)) u_aw_slice (
        .clk(ACLK), .rst_n(ARESETN), .load(user_aw_hs), .req_addr(awaddr), .req_len(awlen),
        .ready(M_AXI_AWREADY), .valid(aw_pending), .addr(M_AXI_AWADDR), .len(aw_len)
    );

    axi_master_req_slice #(.ADDR_WIDTH(C_M_AXI_ADDR_WIDTH)) u_ar_slice (
        .clk(ACLK), .rst_n(ARESETN), .load(user_ar_hs), .req_addr(araddr), .req_len(arlen),
        .ready(M_AXI_ARREADY), .valid(ar_pending), .addr(M_AXI_ARADDR), .len(M_AXI_ARLEN)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wr_state <= W_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next      = wr_state;
        awready      = 1'b0;
        wready       = 1'b0;
        M_AXI_WVALID = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = ready_en && (wr_out < MAX_CNT);
                if (awvalid && ready_en && (wr_out < MAX_CNT)) wr_next = W_DATA;
            end
            W_DATA: begin
                M_AXI_WVALID = wvalid && w_gate;
                wready       = M_AXI_WREADY && w_gate;
                if (wvalid && w_gate && M_AXI_WREADY && wlast)
                    wr_next = (!aw_pending || aw_hs) ? W_IDLE : W_WAITA;
            end
            W_WAITA: if (aw_hs) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // ready_en keeps both user readies low until the first edge after reset release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en   <= 1'b0;
            beat       <= '0;
            wr_out     <= '0;
            rd_out     <= '0;
            err_status <= '0;
        end else begin
            ready_en <= 1'b1;
            if (user_aw_hs)  beat <= '0;
            else if (w_hs)   beat <= beat + 8'd1;
            if (aw_hs && !b_hs)                        wr_out <= wr_out + CW'(1);
            else if (b_hs && !aw_hs && wr_out != '0)   wr_out <= wr_out - CW'(1);
            if (ar_hs && !rlast_hs)                    rd_out <= rd_out + CW'(1);
            else if (rlast_hs && !ar_hs && rd_out != '0) rd_out <= rd_out - CW'(1);
            if (b_hs && M_AXI_BRESP != RESP_OKAY) err_status[0] <= 1'b1;
            if (r_hs && M_AXI_RRESP != RESP_OKAY) err_status[1] <= 1'b1;
        end
    end

    assign arready        = ready_en && !ar_pending && (rd_out < MAX_CNT);

    assign M_AXI_AWID     = '0;
    assign M_AXI_AWLEN    = aw_len;
    assign M_AXI_AWSIZE   = SIZE;
    assign M_AXI_AWBURST  = BURST_INCR;
    assign M_AXI_AWLOCK   = '0;
    assign M_AXI_AWCACHE  = CACHE_DEFAULT;
    assign M_AXI_AWPROT   = '0;
    assign M_AXI_AWREGION = '0;
    assign M_AXI_AWQOS    = '0;
    assign M_AXI_AWUSER   = '0;
    assign M_AXI_AWVALID  = aw_pending;

    assign M_AXI_WDATA    = wdata;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WLAST    = wlast;
    assign M_AXI_WUSER    = '0;

    assign bvalid         = M_AXI_BVALID;
    assign M_AXI_BREADY   = bready;

    assign M_AXI_ARID     = '0;
    assign M_AXI_ARSIZE   = SIZE;
    assign M_AXI_ARBURST  = BURST_INCR;
    assign M_AXI_ARLOCK   = '0;
    assign M_AXI_ARCACHE  = CACHE_DEFAULT;
    assign M_AXI_ARPROT   = '0;
    assign M_AXI_ARREGION = '0;
    assign M_AXI_ARQOS    = '0;
    assign M_AXI_ARUSER   = '0;
    assign M_AXI_ARVALID  = ar_pending;

    assign rdata          = M_AXI_RDATA;
    assign rlast          = M_AXI_RLAST;
    assign rvalid         = M_AXI_RVALID;
    assign M_AXI_RREADY   = rready;

endmodule

// File: tb/tb_axi_master_interface.sv
// Self-checking bench for axi_master_interface: directed steps with randomized beats and a transaction-level model.
module tb_axi_master_interface;
    import axi_master_interface_pkg::*;

    localparam int MAX_OUT = 2;

    logic        ACLK, ARESETN;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [1:0]  err_status;
    logic [0:0]  M_AXI_AWID, M_AXI_AWUSER, M_AXI_WUSER, M_AXI_BID, M_AXI_BUSER;
    logic [0:0]  M_AXI_ARID, M_AXI_ARUSER, M_AXI_RID, M_AXI_RUSER;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_AWPROT, M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]  M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_BRESP, M_AXI_RRESP;
    logic [3:0]  M_AXI_AWCACHE, M_AXI_AWREGION, M_AXI_AWQOS, M_AXI_WSTRB;
    logic [3:0]  M_AXI_ARCACHE, M_AXI_ARREGION, M_AXI_ARQOS;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    axi_master_interface #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_status(err_status),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWREGION(M_AXI_AWREGION),
        .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREGION(M_AXI_ARREGION),
        .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int passed = 0;
    int total  = 0;

    // transaction-level model state
    logic [1:0]  err_m;
    bit          ar_pend_m;
    logic [31:0] ar_addr_m;
    logic [7:0]  ar_len_m;
    int          rd_out_m;
    int          rd_len_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // one read-side cycle: inputs already driven at the negedge; checks then advances to next negedge
    task automatic rcycle(output bit uhs);
        bit exp_ar;
        #1;
        exp_ar = !ar_pend_m && (rd_out_m < MAX_OUT);
        check("arready", arready, exp_ar);
        check("m_arvalid", M_AXI_ARVALID, ar_pend_m);
        if (ar_pend_m) begin
            check("m_araddr", M_AXI_ARADDR, ar_addr_m);
            check("m_arlen", M_AXI_ARLEN, ar_len_m);
        end
        check("rvalid", rvalid, M_AXI_RVALID);
        check("m_rready", M_AXI_RREADY, rready);
        if (M_AXI_RVALID) begin
            check("rdata", rdata, M_AXI_RDATA);
            check("rlast", rlast, M_AXI_RLAST);
        end
        check("err_status_rd", err_status, err_m);
        uhs = arvalid && exp_ar;
        if (ar_pend_m && M_AXI_ARREADY) begin
            ar_pend_m = 1'b0;
            rd_out_m++;
        end
        if (M_AXI_RVALID && rready && M_AXI_RLAST) rd_out_m--;
        if (M_AXI_RVALID && rready && M_AXI_RRESP != RESP_OKAY) err_m[1] = 1'b1;
        if (uhs) begin
            ar_pend_m = 1'b1;
            ar_addr_m = araddr;
            ar_len_m  = arlen;
            rd_len_q.push_back(int'(arlen));
        end
        @(negedge ACLK);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int aw_stall, input bit rand_w,
                            input logic [1:0] bresp, input int abort_after);
        logic [31:0] data [256];
        int beat, cyc;
        bit aw_done, gate, exp_wv, exp_wr;
        for (int i = 0; i < 256; i++) data[i] = $urandom;
        beat = 0; cyc = 0; aw_done = 1'b0;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        #1 check("user_awready", awready, 1'b1);
        @(negedge ACLK);
        awvalid = 1'b0; awaddr = $urandom; awlen = 8'($urandom);
        while (!(beat > len && aw_done) && cyc < 300) begin
            M_AXI_AWREADY = (cyc >= aw_stall);
            wvalid        = (beat <= len) && (rand_w ? ($urandom_range(0, 1) == 1) : 1'b1);
            M_AXI_WREADY  = rand_w ? ($urandom_range(0, 1) == 1) : 1'b1;
            wdata         = data[beat & 255];
            #1;
`ifdef AXI_MASTER_WRITE_AFTER_ADDR_EN
            gate = aw_done;
`else
            gate = 1'b1;
            if (beat > len && !aw_done) check("state_waita", 64'(dut.wr_state), 64'(W_WAITA));
`endif
            check("m_awvalid", M_AXI_AWVALID, !aw_done);
            if (!aw_done) begin
                check("m_awaddr", M_AXI_AWADDR, addr);
                check("m_awlen", M_AXI_AWLEN, 8'(len));
            end
            exp_wv = (beat <= len) && wvalid && gate;
            exp_wr = (beat <= len) && M_AXI_WREADY && gate;
            check("m_wvalid", M_AXI_WVALID, exp_wv);
            check("wready", wready, exp_wr);
            if (exp_wv && M_AXI_WREADY) begin
                check("m_wdata", M_AXI_WDATA, data[beat & 255]);
                check("m_wlast", M_AXI_WLAST, beat == len);
                beat++;
            end
            if (!aw_done && M_AXI_AWREADY) aw_done = 1'b1;
            if (abort_after >= 0 && beat == abort_after) begin
                @(posedge ACLK);
                #2 ARESETN = 1'b0;
                #1;
                check("rst_m_awvalid", M_AXI_AWVALID, 1'b0);
                check("rst_m_wvalid", M_AXI_WVALID, 1'b0);
                check("rst_m_arvalid", M_AXI_ARVALID, 1'b0);
                check("rst_awready", awready, 1'b0);
                check("rst_wready", wready, 1'b0);
                check("rst_arready", arready, 1'b0);
                check("rst_err", err_status, 2'b00);
                check("rst_wr_out", 64'(dut.wr_out), 0);
                check("rst_rd_out", 64'(dut.rd_out), 0);
                check("rst_state", 64'(dut.wr_state), 64'(W_IDLE));
                err_m = '0; ar_pend_m = 1'b0; rd_out_m = 0;
                @(negedge ACLK);
                return;
            end
            @(negedge ACLK);
            cyc++;
        end
        check("write_done", beat > len && aw_done, 1'b1);
        M_AXI_AWREADY = 1'b0; wvalid = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp; bready = 1'b1;
        #1;
        check("bvalid", bvalid, 1'b1);
        check("m_bready", M_AXI_BREADY, 1'b1);
        check("wr_outstanding", 64'(dut.wr_out), 1);
        check("err_status_pre_b", err_status, err_m);
        @(negedge ACLK);
        if (bresp != RESP_OKAY) err_m[0] = 1'b1;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = RESP_OKAY; bready = 1'b0;
        #1;
        check("err_status_post_b", err_status, err_m);
        check("wr_outstanding_done", 64'(dut.wr_out), 0);
        @(negedge ACLK);
    endtask

    initial begin
        int  beat, t, len;
        bit  got, first;
        ARESETN = 1'b0;
        awvalid = 0; awaddr = '0; awlen = '0; wdata = '0; wvalid = 0; bready = 0;
        arvalid = 0; araddr = '0; arlen = '0; rready = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BUSER = '0;
        M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
        M_AXI_RLAST = 0; M_AXI_RUSER = '0; M_AXI_RVALID = 0;
        err_m = '0; ar_pend_m = 0; ar_addr_m = '0; ar_len_m = '0; rd_out_m = 0;

        repeat (3) @(negedge ACLK);
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("reset_awready", awready, 1'b0);
        check("reset_arready", arready, 1'b0);
        check("reset_wready", wready, 1'b0);
        check("reset_m_awvalid", M_AXI_AWVALID, 1'b0);
        check("reset_m_wvalid", M_AXI_WVALID, 1'b0);
        check("reset_m_arvalid", M_AXI_ARVALID, 1'b0);
        check("reset_err", err_status, 2'b00);
        check("awsize", M_AXI_AWSIZE, 3'd2);
        check("awburst", M_AXI_AWBURST, 2'b01);
        check("awcache", M_AXI_AWCACHE, 4'b0011);
        check("arsize", M_AXI_ARSIZE, 3'd2);
        check("arburst", M_AXI_ARBURST, 2'b01);
        check("arcache", M_AXI_ARCACHE, 4'b0011);
        check("wstrb", M_AXI_WSTRB, 4'hF);
        check("awlock_id", {M_AXI_AWLOCK, M_AXI_AWID, M_AXI_AWPROT, M_AXI_AWQOS}, 0);
        @(negedge ACLK);

        // release: no user handshake is allowed on the first edge after deassertion
        ARESETN = 1'b1;
        #1;
        check("release_awready", awready, 1'b0);
        check("release_arready", arready, 1'b0);
        @(negedge ACLK);
        arvalid = 1'b0;

        do_write(32'h1000, 3, 0, 1'b0, RESP_OKAY, -1);

        repeat (4) do_write($urandom, $urandom_range(0, 7), $urandom_range(0, 3), 1'b1, RESP_OKAY, -1);

        do_write($urandom, 0, 5, 1'b0, RESP_OKAY, -1);

        do_write($urandom, $urandom_range(0, 3), 1, 1'b1, RESP_SLVERR, -1);
        repeat (3) begin
            #1 check("err_sticky", err_status, 2'b01);
            @(negedge ACLK);
        end
        do_write($urandom, $urandom_range(0, 5), $urandom_range(0, 2), 1'b1, RESP_OKAY, -1);

        // reads: two fill the outstanding budget, the third must wait for an RLAST
        M_AXI_ARREADY = 1'b1; rready = 1'b1; M_AXI_RVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            arvalid = 1'b1; araddr = $urandom; arlen = 8'($urandom_range(0, 3));
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) rcycle(got);
            check("ar_accept", got, 1'b1);
        end
        arvalid = 1'b0;
        rcycle(got); rcycle(got);
        arvalid = 1'b1; araddr = $urandom; arlen = 8'($urandom_range(0, 3));
        repeat (4) rcycle(got);
        len = rd_len_q.pop_front();
        beat = 0; t = 0;
        while (beat <= len && t < 60) begin
            M_AXI_RVALID = 1'b1; M_AXI_RDATA = $urandom; M_AXI_RLAST = (beat == len);
            M_AXI_RRESP = RESP_OKAY; rready = ($urandom_range(0, 1) == 1);
            got = 1'b0;
            if (rready) beat++;
            rcycle(got);
            t++;
        end
        check("r_burst0_done", beat, len + 1);
        M_AXI_RVALID = 1'b0; rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) rcycle(got);
        check("ar3_accept", got, 1'b1);
        arvalid = 1'b0;
        rcycle(got);
        first = 1'b1;
        while (rd_len_q.size() > 0) begin
            len = rd_len_q.pop_front();
            beat = 0; t = 0;
            while (beat <= len && t < 60) begin
                M_AXI_RVALID = 1'b1; M_AXI_RDATA = $urandom; M_AXI_RLAST = (beat == len);
                M_AXI_RRESP = (first && beat == len) ? RESP_SLVERR : RESP_OKAY;
                rready = ($urandom_range(0, 1) == 1);
                if (rready) beat++;
                rcycle(got);
                t++;
            end
            check("r_burst_done", beat, len + 1);
            first = 1'b0;
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = RESP_OKAY; rready = 1'b0;
        rcycle(got);
        #1 check("err_both", err_status, 2'b11);
        @(negedge ACLK);

        // reset in the middle of an 8-beat write, then a fresh write
        do_write($urandom, 7, 0, 1'b0, RESP_OKAY, 2);
        wvalid = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_AWREADY = 1'b0;
        #1 check("held_reset_err", err_status, 2'b00);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1 check("rerelease_awready", awready, 1'b0);
        @(negedge ACLK);
        do_write($urandom, $urandom_range(0, 7), $urandom_range(0, 3), 1'b1, RESP_OKAY, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
